// File: rtl/mdio_master_ctrl.sv
// MDIO (Clause 22) management master: frames one read or write per request.
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN lets cfg_pre_sup skip the 32-bit preamble.
module mdio_master_ctrl #(
    parameter int CLK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        op,
    input  logic [4:0]  phyad,
    input  logic [4:0]  regad,
    input  logic [15:0] wdata,
    input  logic        cfg_pre_sup,
    output logic        busy,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA, DONE} state_t;

    localparam logic [7:0] PH_LAST  = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_CMD  = 6'd32;
    localparam logic [5:0] BIT_TA   = 6'd46;
    localparam logic [5:0] BIT_TA2  = 6'd47;
    localparam logic [5:0] BIT_DATA = 6'd48;
    localparam logic [5:0] BIT_LAST = 6'd63;

    state_t      state;
    logic [5:0]  bit_cnt;
    logic [7:0]  ph_cnt;
    logic        hi_phase;
    logic        op_q;
    logic [4:0]  phyad_q;
    logic [4:0]  regad_q;
    logic [15:0] wdata_q;
    logic [15:0] shreg;
    logic        ta_err;
    logic        pre_skip;
    logic        accept;
    logic        in_frame;
    logic        ph_end;
    logic        sample_en;
    logic [5:0]  start_bit;
    logic [5:0]  next_bit;
    logic [31:0] acc_tail;
    logic [31:0] cur_tail;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign pre_skip = cfg_pre_sup;
`else
    logic unused_cfg_pre_sup;
    assign unused_cfg_pre_sup = cfg_pre_sup;
    assign pre_skip = 1'b0;
`endif

    // Everything after the preamble: ST, OP, PHYAD, REGAD, write TA, write data.
    function automatic logic [31:0] frame_tail(input logic rd, input logic [4:0] pa,
                                               input logic [4:0] ra, input logic [15:0] wd);
        return {2'b01, rd ? 2'b10 : 2'b01, pa, ra, 2'b10, wd};
    endfunction

    // Bit index runs 0..63 over a full frame; suppressed frames start at index 32.
    function automatic logic frame_bit(input logic [31:0] tail, input logic [5:0] b);
        if (b < BIT_CMD)
            return 1'b1;
        return tail[5'd31 - b[4:0]];
    endfunction

    function automatic logic frame_oe(input logic rd, input logic [5:0] b);
        return !(rd && (b >= BIT_TA));
    endfunction

    function automatic state_t state_of(input logic [5:0] b);
        if (b < BIT_CMD)
            return PRE;
        if (b < BIT_TA)
            return CMD;
        if (b < BIT_DATA)
            return TA;
        return DATA;
    endfunction

    assign accept    = (state == IDLE) && req;
    assign in_frame  = (state != IDLE) && (state != DONE);
    assign ph_end    = (ph_cnt == PH_LAST);
    assign sample_en = in_frame && ph_end && !hi_phase && op_q;
    assign start_bit = pre_skip ? BIT_CMD : 6'd0;
    assign next_bit  = bit_cnt + 6'd1;
    assign acc_tail  = frame_tail(op, phyad, regad, wdata);
    assign cur_tail  = frame_tail(op_q, phyad_q, regad_q, wdata_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ack      <= 1'b0;
            err      <= 1'b0;
            rdata    <= 16'h0000;
            mdc      <= 1'b0;
            mdio_o   <= 1'b1;
            mdio_oe  <= 1'b0;
            bit_cnt  <= 6'd0;
            ph_cnt   <= 8'd0;
            hi_phase <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        bit_cnt  <= start_bit;
                        ph_cnt   <= 8'd0;
                        hi_phase <= 1'b0;
                        mdc      <= 1'b0;
                        state    <= state_of(start_bit);
                        mdio_o   <= frame_bit(acc_tail, start_bit);
                        mdio_oe  <= frame_oe(op, start_bit);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    if (!ph_end) begin
                        ph_cnt <= ph_cnt + 8'd1;
                    end else begin
                        ph_cnt <= 8'd0;
                        if (!hi_phase) begin
                            hi_phase <= 1'b1;
                            mdc      <= 1'b1;
                        end else begin
                            hi_phase <= 1'b0;
                            mdc      <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state   <= DONE;
                                ack     <= 1'b1;
                                mdio_o  <= 1'b1;
                                mdio_oe <= 1'b0;
                                if (op_q) begin
                                    err   <= ta_err;
                                    rdata <= ta_err ? 16'hFFFF : shreg;
                                end
                            end else begin
                                bit_cnt <= next_bit;
                                state   <= state_of(next_bit);
                                mdio_o  <= frame_bit(cur_tail, next_bit);
                                mdio_oe <= frame_oe(op_q, next_bit);
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Captured request fields and read shift path carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op;
            phyad_q <= phyad;
            regad_q <= regad;
            wdata_q <= wdata;
        end
        if (sample_en) begin
            if (bit_cnt == BIT_TA2)
                ta_err <= mdio_i;
            if (bit_cnt >= BIT_DATA)
                shreg <= {shreg[14:0], mdio_i};
        end
    end

endmodule

// File: doc/mdio_master_ctrl.md
MDIO_MASTER_CTRL -- requirements
Module: mdio_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: MDC half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  input  1  transaction request, sampled only while busy=0.
REQ-005 SHALL have port op  input  1  1=read, 0=write.
REQ-006 SHALL have port phyad  input  5  PHY address.
REQ-007 SHALL have port regad  input  5  register address.
REQ-008 SHALL have port wdata  input  16  write data.
REQ-009 SHALL have port cfg_pre_sup  input  1  preamble-suppress request; used only per REQ-032.
REQ-010 SHALL have port busy  output  1  transaction in progress.
REQ-011 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  16  read data, valid from ack and held until the next read's ack.
REQ-013 SHALL have port err  output  1  read turnaround failure, valid with ack.
REQ-014 SHALL have ports mdc  output  1, mdio_o  output  1, mdio_oe  output  1, mdio_i  input  1: MDIO pad signals.

Function
REQ-015 SHALL accept req=1 in IDLE with busy=0 at cycle T, capturing op/phyad/regad/wdata; busy=1 from T+1 until the ack cycle inclusive.
REQ-016 SHALL ignore req while busy=1; the captured fields SHALL NOT change mid-frame.
REQ-017 SHALL implement states IDLE -> PRE -> CMD -> TA -> DATA -> DONE -> IDLE; PRE is skipped per REQ-032.
REQ-018 SHALL time each frame bit as CLK_DIV cycles with mdc=0 followed by CLK_DIV cycles with mdc=1; the first bit starts at T+1.
REQ-019 SHALL update mdio_o/mdio_oe only on the first cycle of a bit's low phase.
REQ-020 SHALL sample mdio_i on the cycle mdc goes 0->1.
REQ-021 SHALL drive PRE as 32 bits of 1 with mdio_oe=1.
REQ-022 SHALL drive CMD as 14 bits, MSB-first: ST=01; OP=10 for read, 01 for write; PHYAD[4:0]; REGAD[4:0].
REQ-023 SHALL drive TA for a write as the 2 bits 1,0 with mdio_oe=1.
REQ-024 SHALL set mdio_oe=0 for both TA bits of a read.
REQ-025 SHALL set err=1 when mdio_i sampled in the second read TA bit is 1.
REQ-026 SHALL drive DATA for a write as wdata[15:0] MSB-first with mdio_oe=1.
REQ-027 SHALL, for a read, keep mdio_oe=0 during DATA and shift mdio_i MSB-first into a 16-bit register; at ack, rdata = that register, or 16'hFFFF if err=1.
REQ-028 SHALL pulse ack for exactly one cycle at T+1+N*2*CLK_DIV, where N=64 with preamble and 32 without; the state returns to IDLE the following cycle, and a new req is accepted from that cycle.
REQ-029 SHALL, in IDLE, hold mdc=0, mdio_oe=0, mdio_o=1.
REQ-030 SHALL count bits with a 6-bit counter (0..63) and the phase with an 8-bit counter (0..CLK_DIV-1); neither wraps within a frame.

Reset
REQ-031 SHALL, with rst=1 at any cycle including mid-frame, abort the frame and on the next edge give: state=IDLE, busy=0, ack=0, err=0, rdata=16'h0000, mdc=0, mdio_o=1, mdio_oe=0; a req sampled together with rst=1 SHALL be discarded.

Configuration
REQ-032 SHALL, with macro MDIO_PREAMBLE_SUPPRESS_EN defined, skip PRE (N=32) for any request accepted while cfg_pre_sup=1; without the macro, cfg_pre_sup SHALL be ignored and PRE SHALL always be sent (N=64).

Verification
REQ-033 SHALL check: CLK_DIV=2, write phyad=5'h03, regad=5'h1F, wdata=16'hA55A -> mdio_o bit stream = 32x1, 01, 01, 00011, 11111, 10, A55A with mdio_oe=1 throughout; ack at T+257.
REQ-034 SHALL check: CLK_DIV=2, read with a PHY model driving 0 then 16'h1234 -> oe=0 from the TA bits onward, rdata=16'h1234, err=0 at ack.
REQ-035 SHALL check: read with mdio_i stuck at 1 -> err=1 and rdata=16'hFFFF at ack.
REQ-036 SHALL check: second req pulsed at T+10 while busy -> ignored; a single frame and a single ack.
REQ-037 SHALL check: rst=1 at bit 40 of a write -> next cycle busy=0, mdc=0, mdio_oe=0, mdio_o=1, no ack; a following req produces a complete frame.
REQ-038 SHALL check: with MDIO_PREAMBLE_SUPPRESS_EN defined, cfg_pre_sup=1, CLK_DIV=2 write -> first bits are ST=01; ack at T+129; same stimulus without the macro gives ack at T+257.
